// File: rtl/or_gate_pkg.sv
// Shared constants and helpers for the or_gate block and its statistics counters.
package or_gate_pkg;

  localparam int CNT_W_DEFAULT = 16;
  localparam int CNT_W_MAX     = 32;

  // A narrower counter should pad its value with ones above its own width.
  // The padded word is then all-ones exactly when the counter itself is full.
  function automatic logic [CNT_W_MAX-1:0] sat_inc(
    input logic [CNT_W_MAX-1:0] cnt,
    input logic                 en
  );
    if (en && (cnt != {CNT_W_MAX{1'b1}})) begin
      return cnt + 1'b1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/or_gate_sat_cnt.sv
// Saturating up-counter with synchronous clear. Clear takes priority over increment.
module or_gate_sat_cnt
  import or_gate_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W_MAX-1:0] q_ext;
  logic [CNT_W_MAX-1:0] q_nxt;

  generate
    if (CNT_W == CNT_W_MAX) begin : g_full
      assign q_ext = q;
    end else begin : g_pad
      logic unused_hi;
      assign q_ext     = {{(CNT_W_MAX-CNT_W){1'b1}}, q};
      assign unused_hi = &q_nxt[CNT_W_MAX-1:CNT_W];
    end
  endgenerate

  assign q_nxt = sat_inc(q_ext, inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      q <= q_nxt[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/or_gate.sv
// Two-input OR with a registered copy, rising-edge pulse and optional activity counters.
// Counters are built only when OR_GATE_STATS_EN is defined; otherwise they read 0.
module or_gate
  import or_gate_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             clr,
  output logic             y,
  output logic             y_q,
  output logic             y_rise,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] high_cnt
);

  logic y_q_d;

  // Reference result: no storage, no clock or reset involvement.
  assign y = a | b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= 1'b0;
      y_q_d <= 1'b0;
    end else begin
      y_q   <= y;
      y_q_d <= y_q;
    end
  end

  assign y_rise = y_q & ~y_q_d;

`ifdef OR_GATE_STATS_EN
  or_gate_sat_cnt #(.CNT_W(CNT_W)) u_rise_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (y_rise),
    .q   (rise_cnt)
  );

  or_gate_sat_cnt #(.CNT_W(CNT_W)) u_high_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (y_q),
    .q   (high_cnt)
  );
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign rise_cnt   = '0;
  assign high_cnt   = '0;
`endif

endmodule

// File: tb/tb_or_gate.sv
// Directed self-checking bench for or_gate; counter expectations follow OR_GATE_STATS_EN.
module tb_or_gate;

  localparam int CNT_W = 4;

  logic             clk;
  logic             clk_en;
  logic             rst;
  logic             a;
  logic             b;
  logic             clr;
  logic             y;
  logic             y_q;
  logic             y_rise;
  logic [CNT_W-1:0] rise_cnt;
  logic [CNT_W-1:0] high_cnt;

  int n_cmp;
  int n_err;
  logic [0:0] exp_q[$];

  or_gate #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .clr      (clr),
    .y        (y),
    .y_q      (y_q),
    .y_rise   (y_rise),
    .rise_cnt (rise_cnt),
    .high_cnt (high_cnt)
  );

  // clock / reset block: clock only toggles once enabled
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  // drive a for n cycles; scoreboard predicts y_q from the applied operands
  task automatic drive_a(input logic val, input int n);
    logic [0:0] e;
    for (int i = 0; i < n; i++) begin
      a = val;
      exp_q.push_back(val | b);
      tick();
      e = exp_q.pop_front();
      check("y_q_track", {31'b0, y_q}, {31'b0, e});
    end
  endtask

  task automatic check_cnt(input string tag, input int exp_rise, input int exp_high);
`ifdef OR_GATE_STATS_EN
    check({tag, "_rise"}, {28'b0, rise_cnt}, exp_rise);
    check({tag, "_high"}, {28'b0, high_cnt}, exp_high);
`else
    check({tag, "_rise"}, {28'b0, rise_cnt}, 0);
    check({tag, "_high"}, {28'b0, high_cnt}, 0);
    if (exp_rise < 0 || exp_high < 0) $display("note: negative expectation in %s", tag);
`endif
  endtask

  logic [1:0] tt_vec [4];
  logic       tt_exp [4];

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    clk_en = 1'b0;
    rst    = 1'b0;
    a      = 1'b0;
    b      = 1'b0;
    clr    = 1'b0;
    tt_vec = '{2'b00, 2'b01, 2'b10, 2'b11};
    tt_exp = '{1'b0, 1'b1, 1'b1, 1'b1};

    // async reset with the clock stopped
    #1 rst = 1'b1;
    #2 rst = 1'b0;

    // truth table, no clock edges
    for (int i = 0; i < 4; i++) begin
      {a, b} = tt_vec[i];
      #20;
      check($sformatf("tt_y_%0d", i), {31'b0, y}, {31'b0, tt_exp[i]});
      check($sformatf("tt_yq_%0d", i), {31'b0, y_q}, 0);
    end

    // reset behaviour
    a = 1'b1;
    b = 1'b1;
    rst = 1'b1;
    #2;
    check("rst_y", {31'b0, y}, 1);
    check("rst_yq", {31'b0, y_q}, 0);
    check("rst_rise", {31'b0, y_rise}, 0);
    check_cnt("rst_cnt", 0, 0);
    clk_en = 1'b1;
    #3 rst = 1'b0;
    tick();
    check("rel_yq", {31'b0, y_q}, 1);
    check("rel_rise", {31'b0, y_rise}, 1);
    check_cnt("rel_cnt", 0, 0);
    tick();
    check("rel2_rise", {31'b0, y_rise}, 0);
    check_cnt("rel2_cnt", 1, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_yq", {31'b0, y_q}, 0);
    check_cnt("mid_rst_cnt", 0, 0);
    rst = 1'b0;

    // counting pattern 1x3, 0x2, 1x4 then one idle edge
    a = 1'b0;
    b = 1'b0;
    pulse_reset();
    drive_a(1'b1, 3);
    drive_a(1'b0, 2);
    drive_a(1'b1, 4);
    drive_a(1'b0, 1);
    check_cnt("count", 2, 7);

    // saturation at 15
    pulse_reset();
    drive_a(1'b1, 20);
    check_cnt("sat", 1, 15);
    drive_a(1'b1, 2);
    check_cnt("sat_hold", 1, 15);

    // clear wins over a pending increment
    a = 1'b0;
    tick();
    pulse_reset();
    a = 1'b1;
    tick();
    check("clr_rise_pre", {31'b0, y_rise}, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_cnt("clr_prio", 0, 0);
    check("clr_yq", {31'b0, y_q}, 1);
    tick();
    check("clr_after_rise", {31'b0, y_rise}, 0);
    check_cnt("clr_after", 0, 1);

    // long high run: gate outputs identical in both builds
    a = 1'b0;
    tick();
    pulse_reset();
    drive_a(1'b1, 10);
    check("run_yq", {31'b0, y_q}, 1);
    check("run_rise", {31'b0, y_rise}, 0);
    check("run_y", {31'b0, y}, 1);
    check_cnt("run_cnt", 1, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
